motor_cmd_sequencer: RTL and testbench
======================================

# motor_cmd_sequencer

Command-side companion to the four-channel motor protection block. Accepts timed motor commands over a valid/ready handshake and drives the packed 8-bit `sel` bus, 4 motors × 2 bits, that feeds the protection stage. Each motor holds its commanded direction for a programmable number of clocks, then falls back to stop and reports completion. A global stop and an optional watchdog put every motor into stop.

## Interface
Parameters:
- `DUR_W`, 16: width of the duration field and of each per-motor counter.
- `WDT_CYCLES`, 1000000: watchdog timeout in clocks. Used only when the watchdog is compiled in.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_ready`, output, 1: the sequencer can accept a command.
- `cmd_motor`, input, 2: target motor index, 0..3.
- `cmd_dir`, input, 2: command code. 00 = stop, 01 = forward, 10 = reverse, 11 = brake.
- `cmd_dur`, input, `DUR_W`: hold time in clocks. 0 means hold indefinitely.
- `all_stop`, input, 1: level-sensitive global stop.
- `sel`, output, 8: motor m drives `sel[2m+1:2m]`. Connects directly to the protection block's `sel`.
- `busy`, output, 4: motor m has a timed command running.
- `done`, output, 4: one-cycle pulse when motor m's timed command expires.
- `wdt_trip`, output, 1: sticky flag, set when the watchdog forces a stop.

## Operation
- A command is accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_ready = !all_stop`. There is no other back-pressure, so one command can be accepted per cycle.
- On acceptance:
  - The target motor's `sel` field loads `cmd_dir`.
  - Its counter loads `cmd_dur`.
  - `busy[m]` is set when `cmd_dur != 0` and `cmd_dir != 00`. Otherwise it is cleared.
- Each motor has a two-state machine:
  - **IDLE**: counter inactive, `busy` = 0, `sel` field holds its last value. It is 00 after a timed expiry and holds the direction after an indefinite command.
  - **RUN**: counter decrements once per clock.
  - When the counter reaches 1 in RUN, the next cycle does three things: the `sel` field becomes 00, `done[m]` pulses for one cycle, and the state returns to IDLE.
- A new command to a motor in RUN preempts it. The new command loads and no `done` pulse is produced for the preempted command.
- Expiry and a new command to the same motor in the same cycle: the new command wins and no `done` pulse is produced. Other motors are unaffected.
- `cmd_dir = 00` with any duration: the field becomes 00, the motor goes to IDLE and no `done` pulse is produced.
- `all_stop` high:
  - All `sel` fields become 00 on the next edge.
  - All counters clear and every motor goes to IDLE.
  - `busy` = 0 and no `done` pulses are produced.
  - It has priority over every other event.
- The sequencer enforces no dead-time or reversal rules. That protection is owned downstream.

## Timing
- Reset (asynchronous, while `rst` = 0) drives these values:
  - `sel` = 8'h00, `busy` = 0, `done` = 0, `wdt_trip` = 0.
  - `cmd_ready` follows `!all_stop`.
  - All counters are 0 and all motors are IDLE.
- Latency: a command accepted at edge N is visible on `sel` after edge N, i.e. one register stage.
- Duration: the direction is driven for exactly `cmd_dur` cycles. `sel` returns to 00 and `done` pulses after edge N+`cmd_dur`.
- `cmd_dur = 1` gives exactly one cycle of direction, then stop plus `done`.
- `cmd_dur` at its maximum value, 2^DUR_W−1, has no wrap: the counter never underflows.
- Reset mid-command aborts it. `done` is not pulsed.

## Configuration
- Macro `MOTOR_SEQ_WATCHDOG_EN`.
- When the macro is defined:
  - A counter counts cycles since the last accepted command.
  - After `WDT_CYCLES` consecutive cycles with no acceptance, the next edge behaves exactly like one cycle of `all_stop` and sets `wdt_trip`.
  - `wdt_trip` stays high until the next accepted command, which clears it on the same edge the command loads.
  - `all_stop` also restarts the watchdog count.
- When the macro is undefined: no watchdog logic is built, `wdt_trip` is tied to 0 and `WDT_CYCLES` is ignored.

## Structure
- Shared package `motor_pkg` holds:
  - Command-code constants `MOTOR_STOP`, `MOTOR_FWD`, `MOTOR_REV`, `MOTOR_BRAKE`.
  - The per-motor state enum, IDLE or RUN.
  - `NUM_MOTORS = 4`.
- Sub-module `motor_seq_channel` contains one motor's field register, counter, state machine and `done` generation. It is instantiated four times.
- The top level contains the command demux, the `all_stop` fan-out and the watchdog.

## Test plan
- Reset release, then motor 1 forward with `cmd_dur` = 5 → `sel` = 8'h04 for 5 cycles, then 8'h00 with `done` = 4'b0010 for one cycle.
- Motor 2 reverse with `cmd_dur` = 0 → `sel` = 8'h20 held for 1000 cycles, `busy[2]` = 0 and no `done`.
- Motor 0 forward with `cmd_dur` = 10, then motor 0 reverse with `cmd_dur` = 3 at cycle 4 → `sel[1:0]` = 10 for 3 cycles, then 00, one `done[0]` pulse only.
- All four motors forward with `cmd_dur` = 20, then `all_stop` asserted at cycle 8 → `sel` = 8'h00 next cycle, `busy` = 0, no `done`, `cmd_ready` = 0 while `all_stop` is high.
- Expiry of motor 3 on the same cycle a new motor 3 brake command with `cmd_dur` = 2 is accepted → `sel[7:6]` = 11 for 2 cycles, one `done[3]` pulse at the end only.
- With `MOTOR_SEQ_WATCHDOG_EN` and `WDT_CYCLES` = 50: motor 1 indefinite forward, then idle → `sel` = 8'h00 and `wdt_trip` = 1 after 51 cycles. The next command clears `wdt_trip`.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared constants and types for the motor command sequencer.
// Holds command codes, the per-motor state enum and the motor count.
package motor_pkg;

    localparam int NUM_MOTORS = 4;

    localparam logic [1:0] MOTOR_STOP  = 2'b00;
    localparam logic [1:0] MOTOR_FWD   = 2'b01;
    localparam logic [1:0] MOTOR_REV   = 2'b10;
    localparam logic [1:0] MOTOR_BRAKE = 2'b11;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_RUN  = 1'b1
    } motor_state_e;

endpackage

// File: rtl/motor_seq_channel.sv
// One motor channel: sel field register, hold counter, IDLE/RUN FSM, done pulse.
// Ports: clk, rst (async low), load/dir/dur (command), stop, field, busy, done.
module motor_seq_channel
    import motor_pkg::*;
#(
    parameter int DUR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             stop,
    input  logic [1:0]       dir,
    input  logic [DUR_W-1:0] dur,
    output logic [1:0]       field,
    output logic             busy,
    output logic             done
);

    motor_state_e     state;
    motor_state_e     state_nx;
    logic [DUR_W-1:0] cnt;
    logic [DUR_W-1:0] cnt_nx;
    logic [1:0]       field_nx;
    logic             done_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= M_IDLE;
            cnt   <= '0;
            field <= MOTOR_STOP;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            field <= field_nx;
            done  <= done_nx;
        end
    end

    // Priority: stop, then a new command (preempts any expiry), then countdown.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        field_nx = field;
        done_nx  = 1'b0;
        if (stop) begin
            state_nx = M_IDLE;
            cnt_nx   = '0;
            field_nx = MOTOR_STOP;
        end else if (load) begin
            field_nx = dir;
            cnt_nx   = dur;
            if (dir != MOTOR_STOP && dur != '0)
                state_nx = M_RUN;
            else
                state_nx = M_IDLE;
        end else begin
            unique case (state)
                M_IDLE: begin
                    cnt_nx = cnt;
                end
                M_RUN: begin
                    // Counter at 1 means the last direction cycle is on sel now.
                    if (cnt == DUR_W'(1)) begin
                        state_nx = M_IDLE;
                        cnt_nx   = '0;
                        field_nx = MOTOR_STOP;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - DUR_W'(1);
                    end
                end
                default: begin
                    state_nx = M_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == M_RUN);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Timed motor command sequencer driving the packed 4x2-bit sel bus.
// Ports: clk, rst (async low), cmd_valid/cmd_ready/cmd_motor/cmd_dir/cmd_dur,
// all_stop, sel[7:0], busy[3:0], done[3:0], wdt_trip.
// Optional watchdog built when MOTOR_SEQ_WATCHDOG_EN is defined.
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int DUR_W      = 16,
    parameter int WDT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_motor,
    input  logic [1:0]            cmd_dir,
    input  logic [DUR_W-1:0]      cmd_dur,
    input  logic                  all_stop,
    output logic [7:0]            sel,
    output logic [NUM_MOTORS-1:0] busy,
    output logic [NUM_MOTORS-1:0] done,
    output logic                  wdt_trip
);

    logic                  accept;
    logic                  stop;
    logic [NUM_MOTORS-1:0] load;

    assign cmd_ready = !all_stop;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        load = '0;
        if (accept)
            load[cmd_motor] = 1'b1;
    end

`ifdef MOTOR_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] idle_cnt;
    logic             wdt_fire;
    logic             trip;

    // Fires once the idle count has reached the limit and this cycle
    // still brings no command; it then acts like one cycle of all_stop.
    assign wdt_fire = !accept && (idle_cnt == WDT_W'(WDT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            trip     <= 1'b0;
        end else begin
            if (accept || all_stop || wdt_fire)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + WDT_W'(1);
            if (accept)
                trip <= 1'b0;
            else if (wdt_fire)
                trip <= 1'b1;
        end
    end

    assign wdt_trip = trip;
    assign stop     = all_stop | wdt_fire;
`else
    // Always 0 when the watchdog is not built.
    assign wdt_trip = (WDT_CYCLES < 0);
    assign stop     = all_stop;
`endif

    for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_ch
        motor_seq_channel #(
            .DUR_W (DUR_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .load  (load[m]),
            .stop  (stop),
            .dir   (cmd_dir),
            .dur   (cmd_dur),
            .field (sel[2*m+1:2*m]),
            .busy  (busy[m]),
            .done  (done[m])
        );
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench for motor_cmd_sequencer: directed scenarios plus
// randomized traffic against a remaining-cycles reference model.
module tb_motor_cmd_sequencer;

    localparam int DW  = 8;
    localparam int WDT = 50;
`ifdef MOTOR_SEQ_WATCHDOG_EN
    localparam int INDEF_CYC = 40;
`else
    localparam int INDEF_CYC = 1000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_motor = '0;
    logic [1:0]    cmd_dir = '0;
    logic [DW-1:0] cmd_dur = '0;
    logic          all_stop = 1'b0;
    logic [7:0]    sel;
    logic [3:0]    busy;
    logic [3:0]    done;
    logic          wdt_trip;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: remaining direction cycles and field per motor.
    int         rem [4];
    logic [1:0] fld [4];
    logic [3:0] m_done;
    int         idle;
    logic       m_trip;

    motor_cmd_sequencer #(
        .DUR_W      (DW),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_dir   (cmd_dir),
        .cmd_dur   (cmd_dur),
        .all_stop  (all_stop),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .wdt_trip  (wdt_trip)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1);
    end

    function automatic logic [7:0] m_sel();
        logic [7:0] s;
        for (int m = 0; m < 4; m++) s[2*m +: 2] = fld[m];
        return s;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int m = 0; m < 4; m++) b[m] = (rem[m] > 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            rem[m] = 0;
            fld[m] = 2'b00;
        end
        m_done = '0;
        idle = 0;
        m_trip = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        bit stp;
        acc = cmd_valid && !all_stop;
        stp = all_stop;
`ifdef MOTOR_SEQ_WATCHDOG_EN
        begin
            bit fire;
            fire = !acc && (idle == WDT);
            stp = stp || fire;
            if (acc) m_trip = 1'b0;
            else if (fire) m_trip = 1'b1;
            idle = (acc || stp) ? 0 : idle + 1;
        end
`endif
        m_done = '0;
        for (int m = 0; m < 4; m++) begin
            if (stp) begin
                fld[m] = 2'b00;
                rem[m] = 0;
            end else if (acc && int'(cmd_motor) == m) begin
                fld[m] = cmd_dir;
                rem[m] = (cmd_dir != 2'b00) ? int'(cmd_dur) : 0;
            end else if (rem[m] > 0) begin
                rem[m]--;
                if (rem[m] == 0) begin
                    fld[m] = 2'b00;
                    m_done[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input int m, input logic [1:0] d, input int du);
        cmd_valid = 1'b1;
        cmd_motor = 2'(m);
        cmd_dir = d;
        cmd_dur = DW'(du);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        all_stop = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        all_stop = 1'b0;
        #1;
        n_checks++;
        if (sel !== 8'h00 || busy !== 4'h0 || done !== 4'h0 ||
            wdt_trip !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_vals sel=%h busy=%b done=%b trip=%b rdy=%b want 00 0 0 0 1",
                     sel, busy, done, wdt_trip, cmd_ready);
        end
        all_stop = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got %b want 0", cmd_ready);
        end
        do_reset();
        send(1, 2'b01, 5);
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (sel !== 8'h00 || busy !== 4'h0 || done !== 4'h0) begin
            n_err++;
            $display("FAIL reset_async sel=%h busy=%b done=%b want 00 0 0", sel, busy, done);
        end
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (sel !== 8'h00 || done !== 4'h0) begin
            n_err++;
            $display("FAIL reset_abort sel=%h done=%b want 00 0", sel, done);
        end
    endtask

    task automatic test_timed();
        do_reset();
        send(1, 2'b01, 5);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (sel !== 8'h04 || done !== 4'h0 || busy !== 4'b0010) begin
                n_err++;
                $display("FAIL timed_hold k=%0d sel=%h done=%b busy=%b want 04 0 0010",
                         k, sel, done, busy);
            end
            if (k < 4) tick();
        end
        tick();
        n_checks++;
        if (sel !== 8'h00 || done !== 4'b0010 || busy !== 4'h0) begin
            n_err++;
            $display("FAIL timed_expire sel=%h done=%b busy=%b want 00 0010 0", sel, done, busy);
        end
        tick();
        n_checks++;
        if (done !== 4'h0) begin
            n_err++;
            $display("FAIL timed_pulse done=%b want 0", done);
        end
    endtask

    task automatic test_indefinite();
        do_reset();
        send(2, 2'b10, 0);
        for (int k = 0; k < INDEF_CYC; k++) begin
            n_checks++;
            if (sel !== 8'h20 || busy[2] !== 1'b0 || done !== 4'h0) begin
                n_err++;
                $display("FAIL indef k=%0d sel=%h busy=%b done=%b want 20 0 0",
                         k, sel, busy, done);
            end
            tick();
        end
    endtask

    task automatic test_preempt();
        int pulses;
        pulses = 0;
        do_reset();
        send(0, 2'b01, 10);
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses += int'(done[0]);
        end
        send(0, 2'b10, 3);
        for (int k = 0; k < 3; k++) begin
            pulses += int'(done[0]);
            n_checks++;
            if (sel[1:0] !== 2'b10) begin
                n_err++;
                $display("FAIL preempt_hold k=%0d sel0=%b want 10", k, sel[1:0]);
            end
            tick();
        end
        n_checks++;
        if (sel[1:0] !== 2'b00 || done !== 4'b0001) begin
            n_err++;
            $display("FAIL preempt_expire sel0=%b done=%b want 00 0001", sel[1:0], done);
        end
        for (int k = 0; k < 12; k++) begin
            pulses += int'(done[0]);
            tick();
        end
        n_checks++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL preempt_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_all_stop();
        int bad;
        bad = 0;
        do_reset();
        for (int m = 0; m < 4; m++) send(m, 2'b01, 20);
        n_checks++;
        if (sel !== 8'h55 || busy !== 4'hf) begin
            n_err++;
            $display("FAIL stop_run sel=%h busy=%b want 55 1111", sel, busy);
        end
        repeat (4) tick();
        all_stop = 1'b1;
        cmd_valid = 1'b1;
        cmd_motor = 2'd0;
        cmd_dir = 2'b11;
        cmd_dur = DW'(5);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stop_ready got %b want 0", cmd_ready);
        end
        tick();
        n_checks++;
        if (sel !== 8'h00 || busy !== 4'h0 || done !== 4'h0) begin
            n_err++;
            $display("FAIL stop_clear sel=%h busy=%b done=%b want 00 0 0", sel, busy, done);
        end
        tick();
        all_stop = 1'b0;
        cmd_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (sel !== 8'h00 || done !== 4'h0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stop_after bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_collision();
        do_reset();
        send(3, 2'b01, 3);
        repeat (2) tick();
        send(3, 2'b11, 2);
        n_checks++;
        if (sel[7:6] !== 2'b11 || done !== 4'h0) begin
            n_err++;
            $display("FAIL coll_load sel3=%b done=%b want 11 0", sel[7:6], done);
        end
        tick();
        n_checks++;
        if (sel[7:6] !== 2'b11 || done !== 4'h0) begin
            n_err++;
            $display("FAIL coll_hold sel3=%b done=%b want 11 0", sel[7:6], done);
        end
        tick();
        n_checks++;
        if (sel[7:6] !== 2'b00 || done !== 4'b1000) begin
            n_err++;
            $display("FAIL coll_expire sel3=%b done=%b want 00 1000", sel[7:6], done);
        end
    endtask

    task automatic test_dur_max();
        int bad;
        bad = 0;
        do_reset();
        send(0, 2'b01, 255);
        for (int k = 0; k < 254; k++) begin
            tick();
            if (sel !== 8'h01 || done !== 4'h0 || busy !== 4'b0001) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL durmax_hold bad_cycles=%0d want 0", bad);
        end
        tick();
        n_checks++;
        if (sel !== 8'h00 || done !== 4'b0001 || busy !== 4'h0) begin
            n_err++;
            $display("FAIL durmax_expire sel=%h done=%b busy=%b want 00 0001 0", sel, done, busy);
        end
    endtask

`ifdef MOTOR_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        send(1, 2'b01, 0);
        repeat (50) tick();
        n_checks++;
        if (sel !== 8'h04 || wdt_trip !== 1'b0) begin
            n_err++;
            $display("FAIL wdt_before sel=%h trip=%b want 04 0", sel, wdt_trip);
        end
        tick();
        n_checks++;
        if (sel !== 8'h00 || wdt_trip !== 1'b1) begin
            n_err++;
            $display("FAIL wdt_fire sel=%h trip=%b want 00 1", sel, wdt_trip);
        end
        send(2, 2'b01, 0);
        n_checks++;
        if (sel !== 8'h10 || wdt_trip !== 1'b0) begin
            n_err++;
            $display("FAIL wdt_clear sel=%h trip=%b want 10 0", sel, wdt_trip);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_motor = 2'($urandom_range(0, 3));
            cmd_dir = 2'($urandom_range(0, 3));
            cmd_dur = ($urandom_range(0, 15) == 0) ? DW'(255) : DW'($urandom_range(0, 8));
            all_stop = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++;
            if (sel !== m_sel() || busy !== m_busy() || done !== m_done ||
                wdt_trip !== m_trip || cmd_ready !== !all_stop) begin
                n_err++;
                $display("FAIL random k=%0d sel=%h/%h busy=%b/%b done=%b/%b trip=%b/%b rdy=%b",
                         k, sel, m_sel(), busy, m_busy(), done, m_done,
                         wdt_trip, m_trip, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        all_stop = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timed();
        test_indefinite();
        test_preempt();
        test_all_stop();
        test_collision();
`ifndef MOTOR_SEQ_WATCHDOG_EN
        test_dur_max();
`endif
`ifdef MOTOR_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
